// File: rtl/subdiv_pkg.sv
// Shared definitions for the subdivision engine: address width, state
// encodings and the object / neighbor RAM address helpers.
package subdiv_pkg;

  localparam int ADDR_WIDTH = 9;

  localparam logic [31:0] VTX_STRIDE  = 32'd3;
  localparam logic [31:0] FACE_STRIDE = 32'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FACE_RD,
    ST_EDGE_SEL,
    ST_INS,
    ST_FINISH
  } builder_state_t;

  typedef enum logic [2:0] {
    IN_IDLE,
    IN_CNT,
    IN_SCAN,
    IN_WR,
    IN_WRC
  } ins_state_t;

  // First coordinate word of 1-based vertex v (3v-2).
  function automatic logic [ADDR_WIDTH-1:0] vtx_addr(input logic [31:0] v);
    logic [31:0] t;
    t = VTX_STRIDE * v - 32'd2;
    return t[ADDR_WIDTH-1:0];
  endfunction

  // Word k of 0-based face f; faces start right after the vertex block (3V+1).
  function automatic logic [ADDR_WIDTH-1:0] face_addr(input logic [31:0] nv,
                                                      input logic [31:0] f,
                                                      input logic [1:0]  k);
    logic [31:0] t;
    t = VTX_STRIDE * nv + 32'd1 + FACE_STRIDE * f + {30'd0, k};
    return t[ADDR_WIDTH-1:0];
  endfunction

  // Base of the neighbor slot of 1-based vertex v; the count word lives here.
  function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [31:0] v,
                                                      input logic [31:0] max_n);
    logic [31:0] t;
    t = (v - 32'd1) * max_n;
    return t[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/nbr_insert.sv
// Inserts neighbor w into the list of vertex u: reads the count, scans the
// existing entries for a duplicate, then appends w and bumps the count.
module nbr_insert
  import subdiv_pkg::*;
#(
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [31:0]           u,
  input  logic [31:0]           w,
  input  logic [31:0]           nbr_do,
  output logic                  ack,
  output logic                  dropped,
  output logic                  nbr_en,
  output logic [ADDR_WIDTH-1:0] nbr_a,
  output logic [3:0]            nbr_we,
  output logic [31:0]           nbr_di
);

  ins_state_t            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base;

  assign base = slot_base(u, 32'(MAX_NEIGHBOR_COUNT));

  // State, list length and scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IN_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Read addresses run one entry ahead of the data they return.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ack     = 1'b0;
    dropped = 1'b0;
    nbr_en  = 1'b0;
    nbr_a   = '0;
    nbr_we  = 4'h0;
    nbr_di  = '0;
    unique case (state_q)
      IN_IDLE: begin
        if (req) begin
          nbr_en  = 1'b1;
          nbr_a   = base;
          state_d = IN_CNT;
        end
      end
      IN_CNT: begin
        nbr_en  = 1'b1;
        nbr_a   = base + 9'd1;
        cnt_d   = nbr_do;
        idx_d   = 32'd1;
        state_d = (nbr_do == 32'd0) ? IN_WR : IN_SCAN;
      end
      IN_SCAN: begin
        nbr_en = 1'b1;
        nbr_a  = base + idx_q[ADDR_WIDTH-1:0] + 9'd1;
        if (nbr_do == w) begin
          ack     = 1'b1;
          state_d = IN_IDLE;
        end else if (idx_q >= cnt_q) begin
          state_d = IN_WR;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end
      IN_WR: begin
        if (cnt_q >= 32'(MAX_NEIGHBOR_COUNT - 1)) begin
          ack     = 1'b1;
          dropped = 1'b1;
          state_d = IN_IDLE;
        end else begin
          nbr_en  = 1'b1;
          nbr_we  = 4'hF;
          nbr_a   = base + cnt_q[ADDR_WIDTH-1:0] + 9'd1;
          nbr_di  = w;
          state_d = IN_WRC;
        end
      end
      IN_WRC: begin
        nbr_en  = 1'b1;
        nbr_we  = 4'hF;
        nbr_a   = base;
        nbr_di  = cnt_q + 32'd1;
        ack     = 1'b1;
        state_d = IN_IDLE;
      end
      default: state_d = IN_IDLE;
    endcase
  end

endmodule

// File: rtl/neighbor_builder.sv
// Builds the per-vertex neighbor table from the face list: clears all count
// words, then for each valid triangle inserts every ordered vertex pair.
module neighbor_builder
  import subdiv_pkg::*;
#(
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           vertex_count,
  input  logic [31:0]           face_count,
  input  logic [31:0]           RAM_OBJ_Do,
  output logic                  RAM_OBJ_EN,
  output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
  output logic [3:0]            RAM_OBJ_WE,
  output logic [31:0]           RAM_OBJ_Di,
  input  logic [31:0]           RAM_NBR_Do,
  output logic                  RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [3:0]            RAM_NBR_WE,
  output logic [31:0]           RAM_NBR_Di,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  bad_index
);

  builder_state_t state_q, state_d;
  logic [31:0]    v_total_q, v_total_d;
  logic [31:0]    f_total_q, f_total_d;
  logic [31:0]    vtx_q, vtx_d;
  logic [31:0]    face_q, face_d;
  logic [31:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [1:0]     rd_q, rd_d;
  logic [2:0]     pair_q, pair_d;
  logic           busy_q, busy_d;
  logic           overflow_q, overflow_d;
  logic           bad_index_q, bad_index_d;

  logic [31:0]           pair_u, pair_w;
  logic                  ins_req, ins_ack, ins_dropped, ins_en;
  logic [ADDR_WIDTH-1:0] ins_a;
  logic [3:0]            ins_we;
  logic [31:0]           ins_di;
  logic                  face_bad;
  logic                  last_face;

  function automatic logic idx_bad(input logic [31:0] idx, input logic [31:0] nv);
    return (idx == 32'd0) || (idx > nv);
  endfunction

  nbr_insert #(
    .MAX_NEIGHBOR_COUNT(MAX_NEIGHBOR_COUNT)
  ) u_ins (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ins_req),
    .u       (pair_u),
    .w       (pair_w),
    .nbr_do  (RAM_NBR_Do),
    .ack     (ins_ack),
    .dropped (ins_dropped),
    .nbr_en  (ins_en),
    .nbr_a   (ins_a),
    .nbr_we  (ins_we),
    .nbr_di  (ins_di)
  );

  assign RAM_OBJ_WE = 4'h0;
  assign RAM_OBJ_Di = 32'd0;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign bad_index  = bad_index_q;

  // The third index arrives straight from the RAM in the last read cycle.
  assign face_bad  = idx_bad(a_q, v_total_q) || idx_bad(b_q, v_total_q) ||
                     idx_bad(RAM_OBJ_Do, v_total_q);
  assign last_face = (face_q + 32'd1) >= f_total_q;

  // Pair order (a,b),(a,c),(b,a),(b,c),(c,a),(c,b): insert w into list of u.
  always_comb begin
    pair_u = a_q;
    pair_w = b_q;
    case (pair_q)
      3'd0: begin pair_u = a_q; pair_w = b_q; end
      3'd1: begin pair_u = a_q; pair_w = c_q; end
      3'd2: begin pair_u = b_q; pair_w = a_q; end
      3'd3: begin pair_u = b_q; pair_w = c_q; end
      3'd4: begin pair_u = c_q; pair_w = a_q; end
      3'd5: begin pair_u = c_q; pair_w = b_q; end
      default: begin pair_u = a_q; pair_w = b_q; end
    endcase
  end

  // Control and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      v_total_q   <= '0;
      f_total_q   <= '0;
      vtx_q       <= '0;
      face_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      rd_q        <= '0;
      pair_q      <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bad_index_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_total_q   <= v_total_d;
      f_total_q   <= f_total_d;
      vtx_q       <= vtx_d;
      face_q      <= face_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      rd_q        <= rd_d;
      pair_q      <= pair_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      bad_index_q <= bad_index_d;
    end
  end

  // Next-state: clear counts, read each face, walk its six pairs.
  always_comb begin
    state_d     = state_q;
    v_total_d   = v_total_q;
    f_total_d   = f_total_q;
    vtx_d       = vtx_q;
    face_d      = face_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    rd_d        = rd_q;
    pair_d      = pair_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q;
    bad_index_d = bad_index_q;
    ins_req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          overflow_d  = 1'b0;
          bad_index_d = 1'b0;
          v_total_d   = vertex_count;
          f_total_d   = face_count;
          vtx_d       = 32'd1;
          face_d      = '0;
          rd_d        = '0;
          pair_d      = '0;
          state_d     = (vertex_count == 32'd0) ? ST_FINISH : ST_CLR;
        end
      end
      ST_CLR: begin
        if (vtx_q >= v_total_q) begin
          face_d  = '0;
          rd_d    = '0;
          state_d = (f_total_q == 32'd0) ? ST_FINISH : ST_FACE_RD;
        end else begin
          vtx_d = vtx_q + 32'd1;
        end
      end
      ST_FACE_RD: begin
        unique case (rd_q)
          2'd0: rd_d = 2'd1;
          2'd1: begin a_d = RAM_OBJ_Do; rd_d = 2'd2; end
          2'd2: begin b_d = RAM_OBJ_Do; rd_d = 2'd3; end
          2'd3: begin
            c_d  = RAM_OBJ_Do;
            rd_d = 2'd0;
            if (face_bad) begin
              bad_index_d = 1'b1;
              face_d      = face_q + 32'd1;
              state_d     = last_face ? ST_FINISH : ST_FACE_RD;
            end else begin
              pair_d  = '0;
              state_d = ST_EDGE_SEL;
            end
          end
          default: rd_d = 2'd0;
        endcase
      end
      ST_EDGE_SEL: begin
        if (pair_q == 3'd6) begin
          face_d  = face_q + 32'd1;
          rd_d    = '0;
          state_d = last_face ? ST_FINISH : ST_FACE_RD;
        end else if (pair_u == pair_w) begin
          pair_d = pair_q + 3'd1;
        end else begin
          ins_req = 1'b1;
          state_d = ST_INS;
        end
      end
      ST_INS: begin
        if (ins_ack) begin
          pair_d  = pair_q + 3'd1;
          state_d = ST_EDGE_SEL;
          if (ins_dropped) begin
            overflow_d = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port drive: the insert engine owns the neighbor port during pair walks.
  always_comb begin
    RAM_OBJ_EN = 1'b0;
    RAM_OBJ_A  = '0;
    RAM_NBR_EN = 1'b0;
    RAM_NBR_A  = '0;
    RAM_NBR_WE = 4'h0;
    RAM_NBR_Di = '0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_CLR: begin
        RAM_OBJ_EN = 1'b1;
        RAM_NBR_EN = 1'b1;
        RAM_NBR_A  = slot_base(vtx_q, 32'(MAX_NEIGHBOR_COUNT));
        RAM_NBR_WE = 4'hF;
      end
      ST_FACE_RD: begin
        RAM_OBJ_EN = 1'b1;
        RAM_NBR_EN = 1'b1;
        RAM_OBJ_A  = face_addr(v_total_q, face_q, rd_q);
      end
      ST_EDGE_SEL, ST_INS: begin
        RAM_OBJ_EN = 1'b1;
        RAM_NBR_EN = 1'b1 | ins_en;
        RAM_NBR_A  = ins_a;
        RAM_NBR_WE = ins_we;
        RAM_NBR_Di = ins_di;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neighbor_builder.sv
// Bench for neighbor_builder: RAM models, a list-based reference model that
// feeds a scoreboard, and a monitor that checks the table at every done pulse.
module tb_neighbor_builder;
  import subdiv_pkg::*;

  localparam int MAXN = 10;
  localparam int MAXV = 16;
  localparam int MAXF = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vertex_count = '0;
  logic [31:0] face_count = '0;
  logic [31:0] RAM_OBJ_Do;
  logic        RAM_OBJ_EN;
  logic [8:0]  RAM_OBJ_A;
  logic [3:0]  RAM_OBJ_WE;
  logic [31:0] RAM_OBJ_Di;
  logic [31:0] RAM_NBR_Do;
  logic        RAM_NBR_EN;
  logic [8:0]  RAM_NBR_A;
  logic [3:0]  RAM_NBR_WE;
  logic [31:0] RAM_NBR_Di;
  logic        busy, done, overflow, bad_index;

  logic [31:0] obj_mem [0:511];
  logic [31:0] nbr_mem [0:511];
  logic        fill_all = 1'b0;
  logic [31:0] fill_val = '0;

  int fa [MAXF];
  int fb [MAXF];
  int fc [MAXF];
  int mlist [MAXV+1][$];

  bit          exp_ovf_q [$];
  bit          exp_bad_q [$];
  int          exp_n_q [$];
  int          exp_addr_q [$];
  logic [31:0] exp_val_q [$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  neighbor_builder #(.MAX_NEIGHBOR_COUNT(MAXN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vertex_count (vertex_count),
    .face_count   (face_count),
    .RAM_OBJ_Do   (RAM_OBJ_Do),
    .RAM_OBJ_EN   (RAM_OBJ_EN),
    .RAM_OBJ_A    (RAM_OBJ_A),
    .RAM_OBJ_WE   (RAM_OBJ_WE),
    .RAM_OBJ_Di   (RAM_OBJ_Di),
    .RAM_NBR_Do   (RAM_NBR_Do),
    .RAM_NBR_EN   (RAM_NBR_EN),
    .RAM_NBR_A    (RAM_NBR_A),
    .RAM_NBR_WE   (RAM_NBR_WE),
    .RAM_NBR_Di   (RAM_NBR_Di),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .bad_index    (bad_index)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (RAM_OBJ_EN) RAM_OBJ_Do <= obj_mem[RAM_OBJ_A];
    if (fill_all) begin
      for (int i = 0; i < 512; i++) nbr_mem[i] <= fill_val;
    end else if (RAM_NBR_EN) begin
      if (RAM_NBR_WE == 4'hF) nbr_mem[RAM_NBR_A] <= RAM_NBR_Di;
      RAM_NBR_Do <= nbr_mem[RAM_NBR_A];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_face(input int f, input int a, input int b, input int c);
    fa[f] = a; fb[f] = b; fc[f] = c;
  endtask

  task automatic load_obj(input int nv, input int nf);
    for (int v = 1; v <= nv; v++)
      for (int k = 0; k < 3; k++) obj_mem[3*v-3+k+1] = $urandom;
    for (int f = 0; f < nf; f++) begin
      obj_mem[3*nv+1+3*f]   = fa[f];
      obj_mem[3*nv+1+3*f+1] = fb[f];
      obj_mem[3*nv+1+3*f+2] = fc[f];
    end
  endtask

  // Reference: every vertex owns a list; faces with a bad index are skipped,
  // each ordered pair of distinct vertices is appended unless already present.
  task automatic model_push(input int nv, input int nf);
    bit ovf, bad, found;
    int idx [3];
    int u, w, n;
    ovf = 0; bad = 0;
    for (int v = 0; v <= MAXV; v++) mlist[v].delete();
    for (int f = 0; f < nf; f++) begin
      idx[0] = fa[f]; idx[1] = fb[f]; idx[2] = fc[f];
      if (idx[0] < 1 || idx[0] > nv || idx[1] < 1 || idx[1] > nv ||
          idx[2] < 1 || idx[2] > nv) begin
        bad = 1;
        continue;
      end
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          if (i == j) continue;
          u = idx[i]; w = idx[j];
          if (u == w) continue;
          found = 0;
          foreach (mlist[u][k]) if (mlist[u][k] == w) found = 1;
          if (found) continue;
          if (mlist[u].size() >= MAXN - 1) ovf = 1;
          else mlist[u].push_back(w);
        end
      end
    end
    n = 0;
    for (int v = 1; v <= nv; v++) begin
      exp_addr_q.push_back((v-1)*MAXN);
      exp_val_q.push_back(mlist[v].size());
      n++;
      foreach (mlist[v][k]) begin
        exp_addr_q.push_back((v-1)*MAXN + k + 1);
        exp_val_q.push_back(mlist[v][k]);
        n++;
      end
    end
    exp_n_q.push_back(n);
    exp_ovf_q.push_back(ovf);
    exp_bad_q.push_back(bad);
  endtask

  task automatic monitor();
    int n, a;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_n_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          n = exp_n_q.pop_front();
          check("overflow", overflow, exp_ovf_q.pop_front());
          check("bad_index", bad_index, exp_bad_q.pop_front());
          for (int i = 0; i < n; i++) begin
            a = exp_addr_q.pop_front();
            v = exp_val_q.pop_front();
            check($sformatf("nbr_mem[%0d]", a), nbr_mem[a], v);
          end
        end
        @(negedge clk);
        check("done_width", done, 64'd0);
        check("busy_after_done", busy, 64'd0);
      end
    end
  endtask

  task automatic run_job(input int nv, input int nf, input string tag, input int poke);
    int prev;
    bit ok;
    load_obj(nv, nf);
    model_push(nv, nf);
    vertex_count = nv;
    face_count   = nf;
    prev = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, 64'd1);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (poke > 0 && i == poke) start = 1'b1;
      if (poke > 0 && i == poke + 1) start = 1'b0;
      if (done_cnt != prev) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_finished"}, ok, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int nv, nf;
    bit hit;
    fork
      monitor();
    join_none

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_obj_port", {RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE, RAM_OBJ_Di}, 64'd0);
    check("rst_nbr_port", {RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di,
                           busy, done, overflow, bad_index}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single triangle.
    set_face(0, 1, 2, 3);
    run_job(3, 1, "tri", 0);
    check("tri_s1_count", nbr_mem[0], 64'd2);
    check("tri_s1_e1", nbr_mem[1], 64'd2);
    check("tri_s1_e2", nbr_mem[2], 64'd3);
    check("tri_s2_count", nbr_mem[10], 64'd2);
    check("tri_s2_e1", nbr_mem[11], 64'd1);
    check("tri_s3_e2", nbr_mem[22], 64'd2);

    // Two triangles sharing edge 1-3.
    set_face(0, 1, 2, 3);
    set_face(1, 1, 3, 4);
    run_job(4, 2, "quad", 0);
    check("quad_s1_count", nbr_mem[0], 64'd3);
    check("quad_s1_e3", nbr_mem[3], 64'd4);

    // Fan around vertex 1 overflowing its list.
    for (int k = 2; k <= 11; k++) set_face(k-2, 1, k, k+1);
    run_job(12, 10, "fan", 0);
    check("fan_s1_count", nbr_mem[0], 64'(MAXN-1));

    // First face holds an out-of-range index.
    set_face(0, 1, 2, 9);
    set_face(1, 1, 2, 3);
    run_job(3, 2, "badidx", 0);

    // Clear only, on a pre-filled table, twice.
    fill_val = 32'hFFFF_FFFF;
    fill_all = 1'b1;
    @(negedge clk);
    fill_all = 1'b0;
    run_job(3, 0, "clr0", 0);
    run_job(3, 0, "clr1", 0);
    check("clr_s3_count", nbr_mem[20], 64'd0);

    // Degenerate face mixed with a normal one.
    set_face(0, 2, 2, 3);
    set_face(1, 1, 2, 3);
    run_job(3, 2, "degen", 0);

    // Randomized faces.
    for (int j = 0; j < 10; j++) begin
      nv = $urandom_range(3, 8);
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        set_face(f, $urandom_range(1, nv), $urandom_range(1, nv), $urandom_range(1, nv));
        if ($urandom_range(0, 7) == 0) fc[f] = ($urandom_range(0, 1) == 0) ? 0 : nv + 1;
      end
      run_job(nv, nf, $sformatf("rnd%0d", j), 0);
    end

    // Asynchronous reset while the insert engine is scanning a list.
    set_face(0, 1, 2, 3);
    set_face(1, 2, 3, 4);
    load_obj(4, 2);
    model_push(4, 2);
    vertex_count = 4;
    face_count   = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dut.u_ins.state_q == IN_SCAN) begin
        hit = 1;
        break;
      end
    end
    check("reach_scan", hit, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_obj_port", {RAM_OBJ_EN, RAM_OBJ_A, RAM_OBJ_WE, RAM_OBJ_Di}, 64'd0);
    check("midrst_nbr_port", {RAM_NBR_EN, RAM_NBR_A, RAM_NBR_WE, RAM_NBR_Di,
                              busy, done, overflow, bad_index}, 64'd0);
    exp_n_q.delete();
    exp_ovf_q.delete();
    exp_bad_q.delete();
    exp_addr_q.delete();
    exp_val_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh start with a start pulse injected while busy.
    nv = done_cnt;
    set_face(0, 1, 2, 3);
    set_face(1, 1, 3, 4);
    run_job(4, 2, "restart", 8);
    repeat (40) @(negedge clk);
    check("restart_single_done", done_cnt, 64'(nv + 1));
    check("restart_idle", busy, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neighbor_builder.md
Name: neighbor_builder

Overview:
- Builds the per-vertex neighbor table in the neighbor RAM from the face list in the object RAM.
- Runs before the averager pass, which reads this table back.
- For each triangle it inserts each pair of distinct vertices into each other's neighbor lists.
- Duplicates are suppressed; a sticky flag reports lists that overflow.

Parameters:
- MAX_NEIGHBOR_COUNT, 10, words per vertex slot in neighbor RAM: 1 count word + up to MAX_NEIGHBOR_COUNT-1 neighbor entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE only
- vertex_count  in  32  number of vertices V (1-based indices 1..V)
- face_count  in  32  number of triangles F
- RAM_OBJ_Do  in  32  object RAM read data
- RAM_OBJ_EN  out  1  object RAM enable
- RAM_OBJ_A  out  9  object RAM word address
- RAM_OBJ_WE  out  4  object RAM byte write enable; always 0
- RAM_OBJ_Di  out  32  object RAM write data; always 0
- RAM_NBR_Do  in  32  neighbor RAM read data
- RAM_NBR_EN  out  1  neighbor RAM enable
- RAM_NBR_A  out  9  neighbor RAM word address
- RAM_NBR_WE  out  4  neighbor RAM byte write enable
- RAM_NBR_Di  out  32  neighbor RAM write data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse on completion
- overflow  out  1  sticky: an insert was dropped because a list was full
- bad_index  out  1  sticky: a face held index 0 or >V; that face is skipped

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: EN, A, WE, Di, busy, done, overflow, bad_index.
  - Internal counters 0.
- RAM model: single port, synchronous. Address/EN registered at edge N; Do valid and sampled at edge N+1. A write occurs at the edge where WE=4'b1111 with EN=1.
- Object RAM layout:
  - Vertex v coordinates at 3v-2..3v.
  - Face f (0-based) indices at FB+3f..FB+3f+2, where FB=3V+1. Each word is a 1-based vertex index.
- Neighbor RAM layout:
  - Vertex v slot base S(v)=(v-1)*MAX_NEIGHBOR_COUNT.
  - S(v) = count c; S(v)+1..S(v)+c = neighbor indices in insertion order.
- Addresses are truncated to 9 bits. Configurations exceeding 512 words are caller error.
- IDLE:
  - EN=0, done=0.
  - On start=1: busy<=1, clear overflow and bad_index, go to CLR.
  - start while busy is ignored.
- CLR:
  - Writes 0 to S(v) for v=1..V, one write per cycle (V cycles).
  - V=0: skip directly to FINISH.
  - Then go to FACE_RD with f=0. If F=0, go to FINISH.
- FACE_RD:
  - Reads three index words into a, b, c (pipelined: 3 address cycles + 1 latency).
  - Any index 0 or >V: set bad_index, advance f.
- EDGE_SEL:
  - Iterates pairs (u,w) in the fixed order (a,b),(a,c),(b,a),(b,c),(c,a),(c,b); insert w into list of u.
  - A pair with u==w (degenerate face) is skipped.
  - After the 6th pair: f<=f+1; if f==F go to FINISH, else FACE_RD.
- INS_CNT: read S(u) to get c.
- INS_SCAN:
  - Read entries S(u)+1..S(u)+c sequentially and compare to w.
  - On match: abort the insert and return to EDGE_SEL.
  - c=0: skip the scan.
- INS_WR:
  - If c >= MAX_NEIGHBOR_COUNT-1: set overflow, no write.
  - Otherwise write w at S(u)+c+1, then write c+1 at S(u) on the next cycle.
- FINISH: done=1 for one cycle, busy<=0, EN<=0, return to IDLE.
- Inactive-cycle outputs:
  - WE=0 except on write cycles.
  - EN=1 throughout busy states.
- Reset mid-operation: immediate return to IDLE. The neighbor RAM contents are then undefined and a new start is required.
- Latency, non-degenerate face, no duplicates: 4 cycles for FACE_RD plus, per pair, 2+c+2 cycles.

Decomposition:
- Package subdiv_pkg:
  - ADDR_WIDTH=9
  - Builder state enum
  - Address helper constants for vertex base 3v-2 and face base 3V+1
  - Shared with the averager.
- Sub-module nbr_insert: the INS_CNT/INS_SCAN/INS_WR sequence.
  - Inputs: req, u, w, and the neighbor RAM port.
  - Outputs: ack, dropped.
  - The top module muxes the neighbor RAM port to nbr_insert while the insert is active.

Test Plan:
- V=3, F=1, face (1,2,3) -> S(1)=2:{2,3}; S(2)=2:{1,3}; S(3)=2:{1,2}; done pulse once; overflow=0, bad_index=0.
- V=4, F=2, faces (1,2,3),(1,3,4) -> v1 {2,3,4}; v2 {1,3}; v3 {1,2,4}; v4 {1,3}; shared edge 1-3 not duplicated.
- MAX_NEIGHBOR_COUNT=4, V=5, fan faces (1,2,3),(1,3,4),(1,4,5) -> v1 count 3 {2,3,4}; 5 dropped; overflow=1.
- V=3, F=2, faces (1,2,9),(1,2,3) -> bad_index=1; first face skipped; result equals the single-triangle case.
- Pre-fill neighbor RAM with 0xFFFFFFFF, V=3, F=0 -> S(1..3)=0, done after CLR; repeat start on the same data gives identical table (counts are re-cleared).
- Assert rst_n=0 during INS_SCAN -> all outputs 0 asynchronously; start pulsed during busy has no effect; fresh start completes normally.
